// File: rtl/mem_loader_pkg.sv
// Shared constants for the memory loader: FSM state encodings, load target
// encodings and the per-port byte strides used to form SRAM byte addresses.
package mem_loader_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_RUN      = 3'd2;
    localparam logic [2:0] ST_DUMP_RD  = 3'd3;
    localparam logic [2:0] ST_DUMP_CAP = 3'd4;
    localparam logic [2:0] ST_DUMP_OUT = 3'd5;

    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

    localparam int unsigned IMEM_STRIDE = 32'd4;
    localparam int unsigned DMEM_STRIDE = 32'd8;

    function automatic logic [63:0] to_byte_addr(input logic [63:0] word_idx,
                                                 input int unsigned stride);
        return word_idx * 64'(stride);
    endfunction

endpackage

// File: rtl/loader_addr_cnt.sv
// Word counter for one load target: clears on a new load, wraps modulo 2^AW
// and flags the increment that rolls it over to zero.
module loader_addr_cnt #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [AW-1:0] o_cnt,
    output logic          o_wrap
);

    logic [AW-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_wrap = i_inc & ~i_clr & (r_cnt == {AW{1'b1}});

    // counter register with clear priority over increment
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt <= {AW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {AW{1'b0}};
        end else if (i_inc) begin
            r_cnt <= r_cnt + {{(AW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Host-side controller that loads a program image into the CPU memories,
// runs the CPU for a set number of cycles and streams a dmem window back out.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int IMEM_AW = 9,
    parameter int DMEM_AW = 10
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        load_req,
    input  logic        run_req,
    input  logic [31:0] run_len,
    input  logic        dump_req,
    input  logic [63:0] dump_base,
    input  logic [15:0] dump_len,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    input  logic        s_target,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        cpu_enable
);

    logic [2:0]         r_state;
    logic [31:0]        r_run_cnt;
    logic [60:0]        r_daddr;
    logic [15:0]        r_dcnt;
    logic               r_load_fin;

    logic               w_accept;
    logic               w_cnt_clr;
    logic               w_imem_inc;
    logic               w_dmem_inc;
    logic [IMEM_AW-1:0] w_imem_cnt;
    logic [DMEM_AW-1:0] w_dmem_cnt;
    logic               w_imem_wrap;
    logic               w_dmem_wrap;
    logic               w_unused;

    assign s_ready    = (r_state == ST_LOAD);
    assign w_accept   = s_valid & s_ready;
    assign w_cnt_clr  = (r_state == ST_IDLE) & load_req;
    assign w_imem_inc = w_accept & (s_target == TGT_IMEM);
    assign w_dmem_inc = w_accept & (s_target == TGT_DMEM);
    assign ren_ext    = 1'b0;
    assign w_unused   = ^{rdata_ext, dump_base[2:0]};

    loader_addr_cnt #(.AW(IMEM_AW)) u_imem_cnt (
        .clk    (clk),
        .arst   (arst),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_imem_inc),
        .o_cnt  (w_imem_cnt),
        .o_wrap (w_imem_wrap)
    );

    loader_addr_cnt #(.AW(DMEM_AW)) u_dmem_cnt (
        .clk    (clk),
        .arst   (arst),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_dmem_inc),
        .o_cnt  (w_dmem_cnt),
        .o_wrap (w_dmem_wrap)
    );

    // control FSM and all registered outputs; strobes default low each cycle
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state     <= ST_IDLE;
            r_run_cnt   <= 32'd0;
            r_daddr     <= 61'd0;
            r_dcnt      <= 16'd0;
            r_load_fin  <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= 64'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            addr_ext    <= 64'd0;
            wen_ext     <= 1'b0;
            wdata_ext   <= 32'd0;
            addr_ext_2  <= 64'd0;
            wen_ext_2   <= 1'b0;
            ren_ext_2   <= 1'b0;
            wdata_ext_2 <= 64'd0;
            cpu_enable  <= 1'b0;
        end else begin
            wen_ext     <= 1'b0;
            addr_ext    <= 64'd0;
            wdata_ext   <= 32'd0;
            wen_ext_2   <= 1'b0;
            ren_ext_2   <= 1'b0;
            addr_ext_2  <= 64'd0;
            wdata_ext_2 <= 64'd0;
            cpu_enable  <= 1'b0;
            r_load_fin  <= 1'b0;
            // load completion: done trails the final write strobe by one cycle
            done        <= r_load_fin;
            if (w_imem_wrap | w_dmem_wrap) begin
                ovf <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (load_req) begin
                        r_state <= ST_LOAD;
                        busy    <= 1'b1;
                        ovf     <= 1'b0;
                    end else if (run_req) begin
                        if (run_len == 32'd0) begin
                            done <= 1'b1;
                        end else begin
                            r_state    <= ST_RUN;
                            r_run_cnt  <= run_len;
                            cpu_enable <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end else if (dump_req) begin
                        if (dump_len == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            r_state    <= ST_DUMP_RD;
                            r_daddr    <= dump_base[63:3];
                            r_dcnt     <= dump_len;
                            ren_ext_2  <= 1'b1;
                            addr_ext_2 <= to_byte_addr({3'b000, dump_base[63:3]}, DMEM_STRIDE);
                            busy       <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (s_target == TGT_DMEM) begin
                            wen_ext_2   <= 1'b1;
                            addr_ext_2  <= to_byte_addr({{(64-DMEM_AW){1'b0}}, w_dmem_cnt}, DMEM_STRIDE);
                            wdata_ext_2 <= s_data;
                        end else begin
                            wen_ext   <= 1'b1;
                            addr_ext  <= to_byte_addr({{(64-IMEM_AW){1'b0}}, w_imem_cnt}, IMEM_STRIDE);
                            wdata_ext <= s_data[31:0];
                        end
                        if (s_last) begin
                            r_state    <= ST_IDLE;
                            busy       <= 1'b0;
                            r_load_fin <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // enable was already raised for the cycle that loaded the count
                    if (r_run_cnt <= 32'd1) begin
                        r_run_cnt <= 32'd0;
                        r_state   <= ST_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        r_run_cnt  <= r_run_cnt - 32'd1;
                        cpu_enable <= 1'b1;
                    end
                end
                ST_DUMP_RD: begin
                    r_state <= ST_DUMP_CAP;
                end
                ST_DUMP_CAP: begin
                    m_data  <= rdata_ext_2;
                    m_valid <= 1'b1;
                    r_state <= ST_DUMP_OUT;
                end
                ST_DUMP_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_data  <= 64'd0;
                        r_daddr <= r_daddr + 61'd1;
                        r_dcnt  <= r_dcnt - 16'd1;
                        if (r_dcnt == 16'd1) begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state    <= ST_DUMP_RD;
                            ren_ext_2  <= 1'b1;
                            addr_ext_2 <= to_byte_addr({3'b000, r_daddr + 61'd1}, DMEM_STRIDE);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
